// File: rtl/stack_pkg.sv
// Shared definitions for the stack sequencer: request opcodes, FSM states and
// the default interrupt vector location.
package stack_pkg;

  typedef enum logic [1:0] {
    OP_INT  = 2'b00,
    OP_CALL = 2'b01,
    OP_RET  = 2'b10,
    OP_RTI  = 2'b11
  } op_e;

  typedef enum logic [3:0] {
    StIdle,
    StCPush,
    StRRd,
    StRWb,
    StIPc,
    StIFlg,
    StIVrd,
    StIVwb,
    StTFrd,
    StTFwb,
    StTPrd,
    StTPwb
  } state_e;

  // Memory address holding the ISR entry address.
  localparam logic [7:0] INT_VEC_ADDR_DFLT = 8'h01;

endpackage

// File: rtl/stack_sequencer.sv
// Multi-cycle stack engine executing the memory side of CALL, RET, INT and RTI.
// Push: mem[SP] <- value, SP <- SP-1.  Pop: SP <- SP+1, value <- mem[SP].
// Ports:
//   clk, rstn                 clock, async active-low reset
//   req_valid/req_op/req_ready request handshake from decode
//   ret_addr, call_target, flags_in, sp_in  operands latched at accept
//   sp_we/sp_wdata            SP (R3) update
//   mem_*                     shared data-memory port (rdata one cycle after re)
//   pc_load/pc_value          PC load
//   flags_load/flags_value    CCR restore (RTI)
//   int_mask                  set on INT completion, cleared on RTI completion
//   busy, done                front-end stall, final-cycle pulse
module stack_sequencer
  import stack_pkg::*;
#(
  parameter int unsigned       ADDR_W       = 8,
  parameter int unsigned       DATA_W       = 8,
  parameter int unsigned       FLAG_W       = 4,
  parameter logic [ADDR_W-1:0] INT_VEC_ADDR = INT_VEC_ADDR_DFLT
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  input  logic [1:0]        req_op,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] ret_addr,
  input  logic [ADDR_W-1:0] call_target,
  input  logic [FLAG_W-1:0] flags_in,
  input  logic [ADDR_W-1:0] sp_in,
  output logic              sp_we,
  output logic [ADDR_W-1:0] sp_wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_re,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_value,
  output logic              flags_load,
  output logic [FLAG_W-1:0] flags_value,
  output logic              int_mask,
  output logic              busy,
  output logic              done
);

  state_e            r_state;
  logic [ADDR_W-1:0] r_sp;
  logic [ADDR_W-1:0] r_ret;
  logic [ADDR_W-1:0] r_tgt;
  logic [FLAG_W-1:0] r_flags;
  logic              r_int_mask;

  // r_sp holds SP as sampled at accept; each state applies its own offset,
  // so the operation kind is fully encoded in the state and needs no latch.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= StIdle;
      r_sp       <= '0;
      r_ret      <= '0;
      r_tgt      <= '0;
      r_flags    <= '0;
      r_int_mask <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (req_valid) begin
            r_sp    <= sp_in;
            r_ret   <= ret_addr;
            r_tgt   <= call_target;
            r_flags <= flags_in;
            unique case (req_op)
              OP_INT:  r_state <= StIPc;
              OP_CALL: r_state <= StCPush;
              OP_RET:  r_state <= StRRd;
              OP_RTI:  r_state <= StTFrd;
              default: r_state <= StIdle;
            endcase
          end
        end
        StCPush: r_state <= StIdle;
        StRRd:   r_state <= StRWb;
        StRWb:   r_state <= StIdle;
        StIPc:   r_state <= StIFlg;
        StIFlg:  r_state <= StIVrd;
        StIVrd:  r_state <= StIVwb;
        StIVwb: begin
          r_state    <= StIdle;
          r_int_mask <= 1'b1;
        end
        StTFrd:  r_state <= StTFwb;
        StTFwb:  r_state <= StTPrd;
        StTPrd:  r_state <= StTPwb;
        StTPwb: begin
          r_state    <= StIdle;
          r_int_mask <= 1'b0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_comb begin
    sp_we       = 1'b0;
    sp_wdata    = '0;
    mem_addr    = '0;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    mem_wdata   = '0;
    pc_load     = 1'b0;
    pc_value    = '0;
    flags_load  = 1'b0;
    flags_value = '0;
    done        = 1'b0;
    unique case (r_state)
      StCPush: begin
        mem_we    = 1'b1;
        mem_addr  = r_sp;
        mem_wdata = DATA_W'(r_ret);
        sp_we     = 1'b1;
        sp_wdata  = r_sp - ADDR_W'(1);
        pc_load   = 1'b1;
        pc_value  = r_tgt;
        done      = 1'b1;
      end
      StRRd: begin
        mem_re   = 1'b1;
        mem_addr = r_sp + ADDR_W'(1);
        sp_we    = 1'b1;
        sp_wdata = r_sp + ADDR_W'(1);
      end
      StRWb: begin
        pc_load  = 1'b1;
        pc_value = ADDR_W'(mem_rdata);
        done     = 1'b1;
      end
      StIPc: begin
        mem_we    = 1'b1;
        mem_addr  = r_sp;
        mem_wdata = DATA_W'(r_ret);
        sp_we     = 1'b1;
        sp_wdata  = r_sp - ADDR_W'(1);
      end
      StIFlg: begin
        mem_we    = 1'b1;
        mem_addr  = r_sp - ADDR_W'(1);
        mem_wdata = DATA_W'(r_flags);
        sp_we     = 1'b1;
        sp_wdata  = r_sp - ADDR_W'(2);
      end
      StIVrd: begin
        mem_re   = 1'b1;
        mem_addr = INT_VEC_ADDR;
      end
      StIVwb: begin
        pc_load  = 1'b1;
        pc_value = ADDR_W'(mem_rdata);
        done     = 1'b1;
      end
      StTFrd: begin
        mem_re   = 1'b1;
        mem_addr = r_sp + ADDR_W'(1);
        sp_we    = 1'b1;
        sp_wdata = r_sp + ADDR_W'(1);
      end
      StTFwb: begin
        flags_load  = 1'b1;
        flags_value = mem_rdata[FLAG_W-1:0];
      end
      StTPrd: begin
        mem_re   = 1'b1;
        mem_addr = r_sp + ADDR_W'(2);
        sp_we    = 1'b1;
        sp_wdata = r_sp + ADDR_W'(2);
      end
      StTPwb: begin
        pc_load  = 1'b1;
        pc_value = ADDR_W'(mem_rdata);
        done     = 1'b1;
      end
      default: ;
    endcase
  end

  assign req_ready = (r_state == StIdle);
  assign busy      = (r_state != StIdle);
  assign int_mask  = r_int_mask;

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed bench for stack_sequencer with a behavioural data memory.
module tb_stack_sequencer;
  import stack_pkg::*;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       req_valid = 1'b0;
  logic [1:0] req_op = 2'b00;
  logic       req_ready;
  logic [7:0] ret_addr = 8'h00;
  logic [7:0] call_target = 8'h00;
  logic [3:0] flags_in = 4'h0;
  logic [7:0] sp_in = 8'h00;
  logic       sp_we;
  logic [7:0] sp_wdata;
  logic [7:0] mem_addr;
  logic       mem_we;
  logic       mem_re;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = 8'h00;
  logic       pc_load;
  logic [7:0] pc_value;
  logic       flags_load;
  logic [3:0] flags_value;
  logic       int_mask;
  logic       busy;
  logic       done;

  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  stack_sequencer dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .req_ready  (req_ready),
    .ret_addr   (ret_addr),
    .call_target(call_target),
    .flags_in   (flags_in),
    .sp_in      (sp_in),
    .sp_we      (sp_we),
    .sp_wdata   (sp_wdata),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .pc_load    (pc_load),
    .pc_value   (pc_value),
    .flags_load (flags_load),
    .flags_value(flags_value),
    .int_mask   (int_mask),
    .busy       (busy),
    .done       (done)
  );

  // Data memory with a bench-side preload port.
  logic [7:0] mem [256];
  logic       pre_we = 1'b0;
  logic [7:0] pre_addr = 8'h00;
  logic [7:0] pre_data = 8'h00;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  // Bus monitor.
  logic [7:0] last_sp = 8'h00;
  logic [3:0] last_flags = 4'h0;
  logic [7:0] last_rd = 8'h00;
  int n_done = 0;
  int n_vec = 0;
  int n_wr = 0;
  int n_both = 0;

  always @(negedge clk) begin
    if (sp_we) last_sp <= sp_wdata;
    if (flags_load) last_flags <= flags_value;
    if (mem_re) last_rd <= mem_addr;
    if (done) n_done <= n_done + 1;
    if (mem_re && mem_addr == 8'h01) n_vec <= n_vec + 1;
    if (mem_we) n_wr <= n_wr + 1;
    if (mem_we && mem_re) n_both <= n_both + 1;
  end

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  // Issue one request; returns latency from accept edge to done and the PC
  // presented in the done cycle. Ends one edge after done.
  task automatic run_op(input logic [1:0] op, input logic [7:0] sp, input logic [7:0] ret,
                        input logic [7:0] tgt, input logic [3:0] flg, input bit hold,
                        output int lat, output logic [7:0] pc, output logic ready0);
    @(negedge clk);
    req_op = op; sp_in = sp; ret_addr = ret; call_target = tgt; flags_in = flg;
    req_valid = 1'b1;
    ready0 = req_ready;
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
    lat = 0;
    pc = 8'h00;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (done) begin
        lat = n;
        pc = pc_load ? pc_value : 8'hxx;
        req_valid = 1'b0;
        break;
      end
    end
    req_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({sp_we, mem_we, mem_re, pc_load, flags_load, int_mask, busy, done} !== 8'h00) begin
      fails++;
      $display("FAIL reset_strobes: got %b expected 00000000",
               {sp_we, mem_we, mem_re, pc_load, flags_load, int_mask, busy, done});
    end
    checks++;
    if ({sp_wdata, mem_addr, mem_wdata, pc_value, flags_value} !== 36'h0) begin
      fails++;
      $display("FAIL reset_data: got %h expected 0",
               {sp_wdata, mem_addr, mem_wdata, pc_value, flags_value});
    end
    checks++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: got %b expected 1", req_ready);
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_call_ret;
    int lat;
    logic [7:0] pc;
    logic rdy;
    run_op(OP_CALL, 8'hFF, 8'h05, 8'h20, 4'h0, 1'b0, lat, pc, rdy);
    checks++;
    if (rdy !== 1'b1) begin fails++; $display("FAIL call_ready: got %b expected 1", rdy); end
    checks++;
    if (lat !== 1) begin fails++; $display("FAIL call_latency: got %0d expected 1", lat); end
    checks++;
    if (pc !== 8'h20) begin fails++; $display("FAIL call_pc: got %h expected 20", pc); end
    checks++;
    if (mem[8'hFF] !== 8'h05) begin
      fails++; $display("FAIL call_mem: got %h expected 05", mem[8'hFF]);
    end
    checks++;
    if (last_sp !== 8'hFE) begin fails++; $display("FAIL call_sp: got %h expected FE", last_sp); end
    // Back-to-back RET.
    run_op(OP_RET, 8'hFE, 8'h00, 8'h00, 4'h0, 1'b0, lat, pc, rdy);
    checks++;
    if (lat !== 2) begin fails++; $display("FAIL ret_latency: got %0d expected 2", lat); end
    checks++;
    if (pc !== 8'h05) begin fails++; $display("FAIL ret_pc: got %h expected 05", pc); end
    checks++;
    if (last_rd !== 8'hFF) begin
      fails++; $display("FAIL ret_rd_addr: got %h expected FF", last_rd);
    end
    checks++;
    if (last_sp !== 8'hFF) begin fails++; $display("FAIL ret_sp: got %h expected FF", last_sp); end
  endtask

  task automatic test_int_rti;
    int lat;
    logic [7:0] pc;
    logic rdy;
    preload(8'h01, 8'h80);
    run_op(OP_INT, 8'hFF, 8'h40, 8'h00, 4'hA, 1'b0, lat, pc, rdy);
    checks++;
    if (lat !== 4) begin fails++; $display("FAIL int_latency: got %0d expected 4", lat); end
    checks++;
    if (pc !== 8'h80) begin fails++; $display("FAIL int_pc: got %h expected 80", pc); end
    checks++;
    if ({mem[8'hFF], mem[8'hFE]} !== 16'h400A) begin
      fails++; $display("FAIL int_mem: got %h expected 400A", {mem[8'hFF], mem[8'hFE]});
    end
    checks++;
    if (last_sp !== 8'hFD) begin fails++; $display("FAIL int_sp: got %h expected FD", last_sp); end
    checks++;
    if (int_mask !== 1'b1) begin fails++; $display("FAIL int_mask_set: got %b expected 1", int_mask); end
    run_op(OP_RTI, 8'hFD, 8'h00, 8'h00, 4'h0, 1'b0, lat, pc, rdy);
    checks++;
    if (lat !== 4) begin fails++; $display("FAIL rti_latency: got %0d expected 4", lat); end
    checks++;
    if (last_flags !== 4'hA) begin
      fails++; $display("FAIL rti_flags: got %h expected A", last_flags);
    end
    checks++;
    if (pc !== 8'h40) begin fails++; $display("FAIL rti_pc: got %h expected 40", pc); end
    checks++;
    if (last_sp !== 8'hFF) begin fails++; $display("FAIL rti_sp: got %h expected FF", last_sp); end
    checks++;
    if (int_mask !== 1'b0) begin fails++; $display("FAIL rti_mask_clr: got %b expected 0", int_mask); end
  endtask

  task automatic test_wrap;
    int lat;
    logic [7:0] pc;
    logic rdy;
    run_op(OP_CALL, 8'h00, 8'h11, 8'h30, 4'h0, 1'b0, lat, pc, rdy);
    checks++;
    if (mem[8'h00] !== 8'h11) begin
      fails++; $display("FAIL wrap_call_mem: got %h expected 11", mem[8'h00]);
    end
    checks++;
    if (last_sp !== 8'hFF) begin fails++; $display("FAIL wrap_call_sp: got %h expected FF", last_sp); end
    run_op(OP_RET, 8'hFF, 8'h00, 8'h00, 4'h0, 1'b0, lat, pc, rdy);
    checks++;
    if (last_rd !== 8'h00) begin fails++; $display("FAIL wrap_ret_addr: got %h expected 00", last_rd); end
    checks++;
    if (pc !== 8'h11) begin fails++; $display("FAIL wrap_ret_pc: got %h expected 11", pc); end
    checks++;
    if (last_sp !== 8'h00) begin fails++; $display("FAIL wrap_ret_sp: got %h expected 00", last_sp); end
  endtask

  task automatic test_hold_int;
    int lat;
    logic [7:0] pc;
    logic rdy;
    int d0, v0, w0;
    d0 = n_done; v0 = n_vec; w0 = n_wr;
    run_op(OP_INT, 8'hF0, 8'h66, 8'h00, 4'h3, 1'b1, lat, pc, rdy);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (n_done - d0 !== 1) begin fails++; $display("FAIL hold_done_count: got %0d expected 1", n_done - d0); end
    checks++;
    if (n_vec - v0 !== 1) begin fails++; $display("FAIL hold_vec_reads: got %0d expected 1", n_vec - v0); end
    checks++;
    if (n_wr - w0 !== 2) begin fails++; $display("FAIL hold_writes: got %0d expected 2", n_wr - w0); end
    checks++;
    if ({busy, int_mask} !== 2'b01) begin
      fails++; $display("FAIL hold_idle_mask: got %b expected 01", {busy, int_mask});
    end
  endtask

  task automatic test_reset_mid;
    int v0;
    preload(8'h7F, 8'hEE);
    v0 = n_vec;
    @(negedge clk);
    req_op = OP_INT; sp_in = 8'h80; ret_addr = 8'h55; flags_in = 4'h5; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);            // I_PC
    @(negedge clk);            // I_FLG
    #1 rstn = 1'b0;
    #1;
    checks++;
    if ({sp_we, mem_we, mem_re, pc_load, flags_load, int_mask, busy, done} !== 8'h00) begin
      fails++;
      $display("FAIL midrst_strobes: got %b expected 00000000",
               {sp_we, mem_we, mem_re, pc_load, flags_load, int_mask, busy, done});
    end
    checks++;
    if ({sp_wdata, mem_addr, mem_wdata, pc_value} !== 32'h0) begin
      fails++; $display("FAIL midrst_data: got %h expected 0", {sp_wdata, mem_addr, mem_wdata, pc_value});
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1) begin fails++; $display("FAIL midrst_ready: got %b expected 1", req_ready); end
    checks++;
    if (n_vec !== v0) begin fails++; $display("FAIL midrst_vec_read: got %0d expected %0d", n_vec, v0); end
    checks++;
    if ({mem[8'h80], mem[8'h7F]} !== 16'h55EE) begin
      fails++; $display("FAIL midrst_mem: got %h expected 55EE", {mem[8'h80], mem[8'h7F]});
    end
  endtask

  initial begin
    test_reset();
    test_call_ret();
    test_int_rti();
    test_wrap();
    test_hold_int();
    test_reset_mid();
    checks++;
    if (n_both !== 0) begin fails++; $display("FAIL we_re_overlap: got %0d expected 0", n_both); end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
